uart_tx_serializer: RTL and testbench

//  Drains bytes from the transmit UART FIFO and serializes each one onto the UART TX line.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_serializer.sv | 109 ++++++++++
 tb/tb_uart_tx_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and frame constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with sync clear
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int            W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    // pre_tick lets callers register a signal that lands on the bit's final cycle
    assign bit_tick = (count == LAST);
    assign pre_tick = (count == PRE);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - drains the TX FIFO and serializes bytes onto the UART line
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    tx_state_t  state, state_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       stop_cnt, stop_cnt_nxt;
    logic       par, par_nxt;
    logic       tx_nxt;
    logic       bit_tick, pre_tick, last_stop;

    // Counter restarts on every state change so each state begins a fresh bit period
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_nxt != state),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        par_nxt      = par;
        case (state)
            IDLE:   if (!fifo_empty) state_nxt = LOAD;
            LOAD:   state_nxt = FETCH;
            FETCH: begin
                shreg_nxt    = fifo_rd_data;
                par_nxt      = (^fifo_rd_data) ^ (PARITY_ODD != 0);
                bit_cnt_nxt  = '0;
                stop_cnt_nxt = 1'b0;
                state_nxt    = START;
            end
            START:  if (bit_tick) state_nxt = DATA;
            DATA: begin
                if (bit_tick) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: if (bit_tick) state_nxt = STOP;
            STOP: begin
                if (bit_tick) begin
                    if (last_stop) state_nxt = IDLE;
                    else           stop_cnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Line level is derived from the upcoming state so tx can be registered
        case (state_nxt)
            START:   tx_nxt = START_LEVEL;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = par_nxt;
            default: tx_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par        <= 1'b0;
            tx         <= IDLE_LEVEL;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            par        <= par_nxt;
            tx         <= tx_nxt;
            fifo_rd_en <= (state_nxt == LOAD);
            busy       <= (state_nxt != IDLE);
            tx_done    <= (state == STOP) && last_stop && pre_tick;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench over three frame configurations
module tb_uart_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [2:0] done_flags = 3'b000;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int CPB  = (g == 2) ? 3 : 4;
        localparam int PE   = (g == 0) ? 0 : 1;
        localparam int PO   = (g == 2) ? 1 : 0;
        localparam int SB   = (g == 1) ? 2 : 1;
        localparam int FLEN = 1 + 8 + PE + SB;
        localparam int FCYC = FLEN * CPB;

        logic       rst;
        logic       fifo_empty;
        logic [7:0] rd_data;
        logic       rd_en, tx, busy, tx_done;

        uart_tx_serializer #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO),
            .STOP_BITS    (SB)
        ) dut (
            .clk          (clk),
            .reset        (rst),
            .fifo_empty   (fifo_empty),
            .fifo_rd_data (rd_data),
            .fifo_rd_en   (rd_en),
            .tx           (tx),
            .busy         (busy),
            .tx_done      (tx_done)
        );

        logic [7:0]  fifo_q[$];
        logic [15:0] exp_q[$];
        logic [15:0] cur;
        bit in_frame = 0;
        int cyc = 0, rd_cyc = -100, exp_rd_cyc = -1, pos = 0;
        int rd_pulses = 0, dones = 0, frames = 0, pushed = 0;

        task automatic ck(string name, logic [31:0] act, logic [31:0] exp);
            chk($sformatf("cfg%0d_%s", g, name), act, exp);
        endtask

        // Expected line image of one frame, bit 0 first on the wire
        function automatic logic [15:0] frame_of(logic [7:0] b);
            logic [15:0] f;
            f = '1;
            f[0] = 1'b0;
            for (int i = 0; i < 8; i++) f[1 + i] = b[i];
            if (PE != 0) f[9] = (($countones(b) % 2) == 1) ^ (PO != 0);
            return f;
        endfunction

        task automatic push(logic [7:0] b);
            fifo_q.push_back(b);
            exp_q.push_back(frame_of(b));
            pushed++;
            fifo_empty = 1'b0;
        endtask

        task automatic monitor();
            cyc++;
            if (rst) begin
                ck("rst_tx", tx, 1);
                ck("rst_busy", busy, 0);
                ck("rst_rd_en", rd_en, 0);
                ck("rst_tx_done", tx_done, 0);
                in_frame   = 0;
                exp_rd_cyc = -1;
                return;
            end
            if (rd_en) begin
                rd_pulses++;
                ck("rd_when_empty", (fifo_q.size() == 0), 0);
                ck("rd_while_frame", in_frame, 0);
                if (exp_rd_cyc >= 0) ck("b2b_rd_cycle", cyc, exp_rd_cyc);
                exp_rd_cyc = -1;
                rd_cyc = cyc;
                if (fifo_q.size() > 0) rd_data = fifo_q.pop_front();
                fifo_empty = (fifo_q.size() == 0);
            end
            if (tx_done) dones++;
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1;
                    pos = 0;
                    ck("start_latency", cyc, rd_cyc + 2);
                    ck("unexpected_start", (exp_q.size() == 0), 0);
                    cur = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
                end else begin
                    ck("idle_tx_done", tx_done, 0);
                end
            end else begin
                pos++;
            end
            if (in_frame) begin
                ck("frame_bit", tx, cur[pos / CPB]);
                ck("tx_done", tx_done, (pos == FCYC - 1));
                ck("busy", busy, 1);
                if (pos == FCYC - 1) begin
                    in_frame = 0;
                    frames++;
                    if (fifo_q.size() > 0) exp_rd_cyc = cyc + 2;
                end
            end
        endtask

        task automatic tick(int n);
            repeat (n) begin
                @(negedge clk);
                monitor();
            end
        endtask

        task automatic wait_idle(int budget);
            int n = 0;
            while ((in_frame || fifo_q.size() > 0 || exp_q.size() > 0 || busy) && n < budget) begin
                tick(1);
                n++;
            end
            ck("idle_timeout", (n >= budget), 0);
            tick(3);
        endtask

        initial begin : stim
            int n;
            rst        = 1'b1;
            fifo_empty = 1'b0;
            rd_data    = 8'h00;
            tick(3);
            rst        = 1'b0;
            fifo_empty = 1'b1;
            tick(10);
            ck("no_rd_after_reset", rd_pulses, 0);

            push(8'hA5);
            wait_idle(500);
            ck("single_done", dones, 1);

            push(8'h00);
            push(8'hFF);
            wait_idle(500);
            ck("b2b_rd_pulses", rd_pulses, 3);

            push(8'h07);
            wait_idle(500);
            push(8'h3C);
            wait_idle(500);
            ck("frames_so_far", frames, 5);

            push(8'h55);
            n = 0;
            while (!(in_frame && pos == CPB * 4 + 1) && n < 500) begin
                tick(1);
                n++;
            end
            ck("reach_d3_timeout", (n >= 500), 0);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            tick(40);
            ck("no_rd_after_midreset", rd_pulses, 6);
            ck("no_done_after_midreset", dones, 5);

            for (int k = 0; k < 12; k++) begin
                int nb;
                nb = $urandom_range(1, 3);
                for (int j = 0; j < nb; j++) push(8'($urandom));
                tick($urandom_range(0, FCYC * 2));
            end
            wait_idle(5000);
            ck("total_rd_pulses", rd_pulses, pushed);
            ck("total_tx_done", dones, pushed - 1);
            ck("total_frames", frames, pushed - 1);
            done_flags[g] = 1'b1;
        end
    end

    initial begin : finish_ctl
        int n;
        n = 0;
        while (done_flags != 3'b111 && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (done_flags != 3'b111) begin
            failures++;
            $display("FAIL global_timeout: got done_flags=%0d expected 7", done_flags);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
